// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access-code fields, size encodings and FSM states for the memory-stage controller
package mem_pkg;

  // Bit positions inside memory_access_code
  localparam int CODE_STORE    = 0;
  localparam int CODE_SIZE_LO  = 1;
  localparam int CODE_SIZE_HI  = 2;
  localparam int CODE_UNSIGNED = 3;
  localparam int CODE_MEMOP    = 4;

  // Access size encodings
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Number of bytes touched by an access; the illegal size is treated as a word
  // here and rejected separately by the fault check.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lane_rotator.sv
// rtl/lane_rotator.sv - maps big-endian datum bytes onto the four byte lanes and back
module lane_rotator
  import mem_pkg::*;
(
  input  logic [1:0]  i_rot,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lane_rdata,
  output logic [31:0] o_lane_wdata,
  output logic [3:0]  o_lane_mask,
  output logic [31:0] o_rdata
);

  logic [2:0] w_nbytes;

  assign w_nbytes = size_bytes(i_size);

  // Datum byte k (k=0 is the MSB) lives at address A+k, i.e. lane (rot+k)%4;
  // the datum itself is right-justified, so byte k sits at bit (n-1-k)*8.
  always_comb begin : rotate
    logic [1:0] lane;
    int         pos;
    o_lane_wdata = '0;
    o_lane_mask  = '0;
    o_rdata      = '0;
    lane         = '0;
    pos          = 0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_nbytes) begin
        lane = i_rot + 2'(k);
        pos  = (int'(w_nbytes) - 1 - k) * 8;
        o_lane_wdata[{lane, 3'b000} +: 8] = i_wdata[pos +: 8];
        o_rdata[pos +: 8]                 = i_lane_rdata[{lane, 3'b000} +: 8];
        o_lane_mask[lane]                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - CPU memory-stage sequencer for four byte-lane BRAMs
module mem_access_controller
  import mem_pkg::*;
#(
  parameter int LANE_AW      = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           memory_access_code,
  input  logic [31:0]          memory_address,
  input  logic [31:0]          data_to_store,
  input  logic [4:0]           req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          writeback_register_data,
  output logic [4:0]           resp_tag,
  output logic                 access_fault,
  output logic [4*LANE_AW-1:0] bram_address,
  output logic [31:0]          bram_wdata,
  output logic [3:0]           bram_we,
  input  logic [31:0]          bram_rdata,
  output logic                 stall
);

  localparam int BYTE_AW = LANE_AW + 2;
  localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e             r_state;
  logic [3:0]         r_code;
  logic [BYTE_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [4:0]         r_tag;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_resp_valid;
  logic               r_fault;
  logic [31:0]        r_wb_data;

  logic [1:0]         w_req_size;
  logic [2:0]         w_req_nbytes;
  logic [BYTE_AW:0]   w_last_byte;
  logic               w_fault;
  logic               w_accept;
  logic [31:0]        w_lane_wdata;
  logic [3:0]         w_lane_mask;
  logic [31:0]        w_datum;
  logic [31:0]        w_ext;

  // Fault check on the incoming request: illegal size, address above the
  // memory, or the last byte running past the top (lanes never wrap).
  assign w_req_size   = memory_access_code[CODE_SIZE_HI:CODE_SIZE_LO];
  assign w_req_nbytes = size_bytes(w_req_size);
  assign w_last_byte  = {1'b0, memory_address[BYTE_AW-1:0]}
                      + {{(BYTE_AW-2){1'b0}}, w_req_nbytes - 3'd1};
  assign w_fault      = (w_req_size == SIZE_BAD)
                      | (|memory_address[31:BYTE_AW])
                      | w_last_byte[BYTE_AW];
  assign w_accept     = req_valid & (r_state == ST_IDLE) & memory_access_code[CODE_MEMOP];

  lane_rotator u_lane_rotator (
    .i_rot        (r_addr[1:0]),
    .i_size       (r_code[CODE_SIZE_HI:CODE_SIZE_LO]),
    .i_wdata      (r_wdata),
    .i_lane_rdata (bram_rdata),
    .o_lane_wdata (w_lane_wdata),
    .o_lane_mask  (w_lane_mask),
    .o_rdata      (w_datum)
  );

  // Lanes below the rotation hold bytes that spilled into the next lane row.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_addr
    logic w_bump;
    assign w_bump = (2'(gi) < r_addr[1:0]);
    assign bram_address[gi*LANE_AW +: LANE_AW] =
      r_addr[BYTE_AW-1:2] + {{(LANE_AW-1){1'b0}}, w_bump};
  end

  // Truncate the assembled datum to the access size and extend it.
  always_comb begin
    w_ext = w_datum;
    case (r_code[CODE_SIZE_HI:CODE_SIZE_LO])
      SIZE_B:  w_ext = {{24{~r_code[CODE_UNSIGNED] & w_datum[7]}}, w_datum[7:0]};
      SIZE_H:  w_ext = {{16{~r_code[CODE_UNSIGNED] & w_datum[15]}}, w_datum[15:0]};
      default: w_ext = w_datum;
    endcase
  end

  // Request/response sequencing; one operation in flight at a time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_code       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag        <= '0;
      r_lat_cnt    <= '0;
      r_resp_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_wb_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_code    <= memory_access_code[3:0];
            r_tag     <= req_tag;
            r_wb_data <= '0;
            if (w_fault) begin
              // Faulting ops leave the BRAM-facing capture registers untouched.
              r_fault      <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_addr  <= memory_address[BYTE_AW-1:0];
              r_wdata <= data_to_store;
              r_fault <= 1'b0;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (r_code[CODE_STORE]) begin
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_wb_data    <= w_ext;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready               = (r_state == ST_IDLE);
  assign stall                   = req_valid & ~req_ready;
  assign resp_valid              = r_resp_valid;
  assign access_fault            = r_fault;
  assign writeback_register_data = r_wb_data;
  assign resp_tag                = r_tag;
  assign bram_wdata              = w_lane_wdata;
  assign bram_we                 = ((r_state == ST_ISSUE) && r_code[CODE_STORE]) ? w_lane_mask : 4'b0000;

endmodule
